ysyx_24080006_axi_sram: RTL

- AXI4 slave/responder: the memory-side end of the core's AXI read and write master channels.
- Consumes axi_r_m2s_t / axi_w_m2s_t and drives axi_r_s2m_t / axi_w_s2m_t from ysyx_24080006_pkg.
- Backs a word-addressed on-chip SRAM window at BASE_ADDR and serves FIXED/INCR/WRAP bursts with byte strobes.
- Used as the simulation memory for icache line fills and LSU traffic, and as a protocol-compliant partner for master verification.

---
 rtl/ysyx_24080006_axi_sram.sv | 311 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_24080006_axi_sram.sv
// AXI4 responder backed by a word-addressed on-chip SRAM window.
// Independent read/write FSMs serve FIXED/INCR/WRAP bursts with byte strobes.

package ysyx_24080006_pkg;
   localparam logic [31:0] RST_ADDR = 32'h8000_0000;

   typedef struct packed {
      logic [31:0] araddr;
      logic [7:0]  arlen;
      logic [2:0]  arsize;
      logic [1:0]  arburst;
      logic        arvalid;
      logic        rready;
   } axi_r_m2s_t;

   typedef struct packed {
      logic        arready;
      logic        rvalid;
      logic [31:0] rdata;
      logic        rlast;
   } axi_r_s2m_t;

   typedef struct packed {
      logic [31:0] awaddr;
      logic [7:0]  awlen;
      logic [2:0]  awsize;
      logic [1:0]  awburst;
      logic        awvalid;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        wlast;
      logic        wvalid;
      logic        bready;
   } axi_w_m2s_t;

   typedef struct packed {
      logic awready;
      logic wready;
      logic bvalid;
   } axi_w_s2m_t;
endpackage

module ysyx_24080006_axi_sram
   import ysyx_24080006_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = RST_ADDR,
   parameter int unsigned MEM_WORDS = 4096,
   parameter int unsigned RD_LAT    = 2,
   parameter int unsigned B_LAT     = 1
) (
   input  logic       clock,
   input  logic       rst_n,
   input  axi_r_m2s_t axi_r_i,
   output axi_r_s2m_t axi_r_o,
   input  axi_w_m2s_t axi_w_i,
   output axi_w_s2m_t axi_w_o,
   output logic       err_o
);
   localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
   localparam logic [31:0] WIN_BYTES = 32'(4 * MEM_WORDS);

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

   function automatic logic in_win(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE_ADDR;
      return (a >= BASE_ADDR) && (off < WIN_BYTES);
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE_ADDR;
      return IDX_W'(off >> 2);
   endfunction

   function automatic logic bad_burst(input logic [7:0] len, input logic [1:0] burst);
      return (burst == 2'b11) ||
             ((burst == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
   endfunction

   // Burst is pre-normalised at latch time, so only FIXED/INCR/WRAP reach here.
   function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst);
      logic [31:0] s, l;
      s = 32'd1 << size;
      l = (32'(len) + 32'd1) << size;
      case (burst)
         2'b00:   return a;
         2'b10:   return (a & ~(l - 32'd1)) | ((a + s) & (l - 32'd1));
         default: return a + s;
      endcase
   endfunction

   logic [31:0] mem [MEM_WORDS];

   logic        rst_done;
   r_state_e    r_state, r_state_d;
   logic [31:0] r_addr, r_addr_d, rd_addr;
   logic [7:0]  r_len, r_len_d, r_beat, r_beat_d;
   logic [2:0]  r_size, r_size_d;
   logic [1:0]  r_burst, r_burst_d;
   logic [3:0]  r_cnt, r_cnt_d;
   logic        arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
   logic [31:0] rdata_q;
   logic        rd_load, r_err;

   w_state_e    w_state, w_state_d;
   logic [31:0] w_addr, w_addr_d;
   logic [7:0]  w_len, w_len_d, w_beat, w_beat_d;
   logic [2:0]  w_size, w_size_d;
   logic [1:0]  w_burst, w_burst_d;
   logic [3:0]  w_cnt, w_cnt_d;
   logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
   logic        wr_en, w_err, err_q;

   // Read path next state and registered-output values.
   always_comb begin
      r_state_d = r_state;
      r_addr_d  = r_addr;
      r_len_d   = r_len;
      r_size_d  = r_size;
      r_burst_d = r_burst;
      r_beat_d  = r_beat;
      r_cnt_d   = r_cnt;
      arready_d = 1'b0;
      rvalid_d  = rvalid_q;
      rlast_d   = rlast_q;
      rd_load   = 1'b0;
      r_err     = 1'b0;
      unique case (r_state)
         R_IDLE: begin
            arready_d = rst_done;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            if (axi_r_i.arvalid && arready_q) begin
               arready_d = 1'b0;
               r_addr_d  = axi_r_i.araddr;
               r_len_d   = axi_r_i.arlen;
               r_size_d  = axi_r_i.arsize;
               r_burst_d = axi_r_i.arburst;
               r_beat_d  = 8'd0;
               r_cnt_d   = 4'd0;
               r_state_d = R_WAIT;
               if (bad_burst(axi_r_i.arlen, axi_r_i.arburst)) begin
                  r_burst_d = 2'b01;
                  r_err     = 1'b1;
               end
            end
         end
         R_WAIT: begin
            if (r_cnt == 4'(RD_LAT - 1)) begin
               r_state_d = R_DATA;
               rvalid_d  = 1'b1;
               rlast_d   = (r_len == 8'd0);
               rd_load   = 1'b1;
            end else begin
               r_cnt_d = r_cnt + 4'd1;
            end
         end
         R_DATA: begin
            if (axi_r_i.rready) begin
               if (rlast_q) begin
                  r_state_d = R_IDLE;
                  rvalid_d  = 1'b0;
                  rlast_d   = 1'b0;
                  arready_d = 1'b1;
               end else begin
                  r_addr_d = next_addr(r_addr, r_len, r_size, r_burst);
                  r_beat_d = r_beat + 8'd1;
                  rlast_d  = ((r_beat + 8'd1) == r_len);
                  rd_load  = 1'b1;
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
      rd_addr = r_addr_d;
      if (rd_load && !in_win(rd_addr)) r_err = 1'b1;
   end

   // Write path next state; memory write strobe is combinational on the W handshake.
   always_comb begin
      w_state_d = w_state;
      w_addr_d  = w_addr;
      w_len_d   = w_len;
      w_size_d  = w_size;
      w_burst_d = w_burst;
      w_beat_d  = w_beat;
      w_cnt_d   = w_cnt;
      awready_d = 1'b0;
      wready_d  = wready_q;
      bvalid_d  = bvalid_q;
      wr_en     = 1'b0;
      w_err     = 1'b0;
      unique case (w_state)
         W_IDLE: begin
            awready_d = rst_done;
            wready_d  = 1'b0;
            bvalid_d  = 1'b0;
            if (axi_w_i.awvalid && awready_q) begin
               awready_d = 1'b0;
               wready_d  = 1'b1;
               w_addr_d  = axi_w_i.awaddr;
               w_len_d   = axi_w_i.awlen;
               w_size_d  = axi_w_i.awsize;
               w_burst_d = axi_w_i.awburst;
               w_beat_d  = 8'd0;
               w_state_d = W_DATA;
               if (bad_burst(axi_w_i.awlen, axi_w_i.awburst)) begin
                  w_burst_d = 2'b01;
                  w_err     = 1'b1;
               end
            end
         end
         W_DATA: begin
            if (axi_w_i.wvalid) begin
               wr_en = 1'b1;
               if (!in_win(w_addr) || (axi_w_i.wlast != (w_beat == w_len))) w_err = 1'b1;
               if (w_beat == w_len) begin
                  w_state_d = W_RESP;
                  wready_d  = 1'b0;
                  w_cnt_d   = 4'd0;
               end else begin
                  w_addr_d = next_addr(w_addr, w_len, w_size, w_burst);
                  w_beat_d = w_beat + 8'd1;
               end
            end
         end
         W_RESP: begin
            if (bvalid_q) begin
               if (axi_w_i.bready) begin
                  w_state_d = W_IDLE;
                  bvalid_d  = 1'b0;
                  awready_d = 1'b1;
               end
            end else if (w_cnt == 4'(B_LAT - 1)) begin
               bvalid_d = 1'b1;
            end else begin
               w_cnt_d = w_cnt + 4'd1;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         rst_done  <= 1'b0;
         r_state   <= R_IDLE;
         r_addr    <= '0;
         r_len     <= '0;
         r_size    <= '0;
         r_burst   <= '0;
         r_beat    <= '0;
         r_cnt     <= '0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rdata_q   <= '0;
         w_state   <= W_IDLE;
         w_addr    <= '0;
         w_len     <= '0;
         w_size    <= '0;
         w_burst   <= '0;
         w_beat    <= '0;
         w_cnt     <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         rst_done  <= 1'b1;
         r_state   <= r_state_d;
         r_addr    <= r_addr_d;
         r_len     <= r_len_d;
         r_size    <= r_size_d;
         r_burst   <= r_burst_d;
         r_beat    <= r_beat_d;
         r_cnt     <= r_cnt_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rlast_q   <= rlast_d;
         if (rd_load) rdata_q <= in_win(rd_addr) ? mem[word_idx(rd_addr)] : 32'h0;
         w_state   <= w_state_d;
         w_addr    <= w_addr_d;
         w_len     <= w_len_d;
         w_size    <= w_size_d;
         w_burst   <= w_burst_d;
         w_beat    <= w_beat_d;
         w_cnt     <= w_cnt_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         err_q     <= err_q | r_err | w_err;
      end
   end

   // Array is not reset; a same-edge read above sees the pre-write word.
   always_ff @(posedge clock) begin
      if (rst_n && wr_en && in_win(w_addr)) begin
         for (int i = 0; i < 4; i++) begin
            if (axi_w_i.wstrb[i]) mem[word_idx(w_addr)][8*i +: 8] <= axi_w_i.wdata[8*i +: 8];
         end
      end
   end

   assign axi_r_o = '{arready: arready_q, rvalid: rvalid_q, rdata: rdata_q, rlast: rlast_q};
   assign axi_w_o = '{awready: awready_q, wready: wready_q, bvalid: bvalid_q};
   assign err_o   = err_q;
endmodule
